hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_ctrl_if.sv | 49 ++++
 rtl/hazard_mul_seq.sv | 81 ++++++++
 rtl/hazard_ctrl.sv | 92 +++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the hazard controller slice:
//               multiply sequencer state encoding, default multiplier latency
//               and the hard-wired zero register index.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  localparam int         MUL_LAT_DEFAULT = 4;
  localparam logic [4:0] REG_ZERO        = 5'd0;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Pipeline <-> hazard controller signal bundle.
//               master : pipeline side, drives ID/EX status and memory waits,
//                        receives the stall/flush controls.
//               slave  : hazard controller side.
// Ports       : id_rs1_addr/id_rs2_addr/id_rs1_used/id_rs2_used (ID sources),
//               ex_rd_addr/ex_mem_read/ex_is_mul/ex_jb (EX status),
//               imem_wait/dmem_wait (memory not ready),
//               stall/mul_stall/jb/ex_bubble/freeze/mul_busy (controls).
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;

  logic [4:0] id_rs1_addr;
  logic [4:0] id_rs2_addr;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] ex_rd_addr;
  logic       ex_mem_read;
  logic       ex_is_mul;
  logic       ex_jb;
  logic       imem_wait;
  logic       dmem_wait;

  logic       stall;
  logic       mul_stall;
  logic       jb;
  logic       ex_bubble;
  logic       freeze;
  logic       mul_busy;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    output ex_rd_addr, ex_mem_read, ex_is_mul, ex_jb,
    output imem_wait, dmem_wait,
    input  stall, mul_stall, jb, ex_bubble, freeze, mul_busy
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    input  ex_rd_addr, ex_mem_read, ex_is_mul, ex_jb,
    input  imem_wait, dmem_wait,
    output stall, mul_stall, jb, ex_bubble, freeze, mul_busy
  );

endinterface
`default_nettype wire

// File: rtl/hazard_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : hazard_mul_seq
// Description : Multi-cycle multiply sequencer. Raises mul_stall for
//               MUL_LAT-1 unfrozen cycles per accepted multiply, then spends
//               one MUL_DONE cycle so the same EX multiply is not re-accepted.
//               freeze holds state and counter without changing mul_stall.
// Ports       : clk, rst (sync, active-high), start (EX is multiply),
//               freeze, mul_stall, busy (state == MUL_BUSY),
//               idle (state == IDLE, used by the top to gate jb).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_mul_seq
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic freeze,
  output logic mul_stall,
  output logic busy,
  output logic idle
);

  // Entry cycle plus MUL_LAT-2 busy cycles with cnt != 0 gives MUL_LAT-1.
  localparam logic [3:0] c_cnt_init = 4'(MUL_LAT - 2);

  mul_state_t r_state;
  mul_state_t w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    mul_stall   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !freeze) begin
          mul_stall   = 1'b1;
          w_state_nxt = MUL_BUSY;
          w_cnt_nxt   = c_cnt_init;
        end
      end
      MUL_BUSY: begin
        if (r_cnt != 4'd0) begin
          mul_stall = 1'b1;
          if (!freeze) begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end else if (!freeze) begin
          w_state_nxt = MUL_DONE;
        end
      end
      MUL_DONE: begin
        // The multiply that just finished is still in EX; ignore ex_is_mul.
        if (!freeze) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy = (r_state == MUL_BUSY);
  assign idle = (r_state == IDLE);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller: load-use detection, branch/jump
//               flush, memory-wait freeze and optional multi-cycle multiply
//               stall. Priority: freeze > mul_stall > jb > load-use.
//               All outputs are forced low while rst is high.
// Config      : HAZARD_MUL_STALL_EN defined   -> multiply sequencer present.
//               HAZARD_MUL_STALL_EN undefined -> single-cycle multiplier,
//               mul_stall/mul_busy tied low, ex_is_mul ignored.
// Ports       : clk, rst (sync, active-high), bus (hazard_ctrl_if.slave).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  if (MUL_LAT < 2 || MUL_LAT > 16) begin : g_bad_mul_lat
    $error("hazard_ctrl: MUL_LAT must be within 2..16");
  end

  logic w_freeze;
  logic w_luse;
  logic w_mul_stall;
  logic w_mul_busy;
  logic w_seq_idle;
  logic w_jb_req;

  assign w_freeze = bus.imem_wait | bus.dmem_wait;

  assign w_luse = bus.ex_mem_read && (bus.ex_rd_addr != REG_ZERO) &&
                  ((bus.id_rs1_used && (bus.id_rs1_addr == bus.ex_rd_addr)) ||
                   (bus.id_rs2_used && (bus.id_rs2_addr == bus.ex_rd_addr)));

`ifdef HAZARD_MUL_STALL_EN
  hazard_mul_seq #(
    .MUL_LAT (MUL_LAT)
  ) u_mul_seq (
    .clk       (clk),
    .rst       (rst),
    .start     (bus.ex_is_mul),
    .freeze    (w_freeze),
    .mul_stall (w_mul_stall),
    .busy      (w_mul_busy),
    .idle      (w_seq_idle)
  );
`else
  logic w_unused;
  assign w_unused    = ^{clk, bus.ex_is_mul};
  assign w_mul_stall = 1'b0;
  assign w_mul_busy  = 1'b0;
  assign w_seq_idle  = 1'b1;
`endif

  // In IDLE, mul_stall high means a multiply is being accepted this cycle,
  // which takes precedence over a branch resolving alongside it.
  assign w_jb_req = bus.ex_jb && !w_freeze && w_seq_idle && !w_mul_stall;

  always_comb begin
    bus.stall     = 1'b0;
    bus.mul_stall = 1'b0;
    bus.jb        = 1'b0;
    bus.ex_bubble = 1'b0;
    bus.freeze    = 1'b0;
    bus.mul_busy  = 1'b0;
    if (!rst) begin
      bus.freeze    = w_freeze;
      bus.mul_stall = w_mul_stall;
      bus.mul_busy  = w_mul_busy;
      if (w_freeze) begin
        bus.stall = 1'b1;
      end else if (!w_mul_stall) begin
        if (w_jb_req) begin
          // Flushed ID instruction is discarded, so no load-use stall.
          bus.jb        = 1'b1;
          bus.ex_bubble = 1'b1;
        end else if (w_luse) begin
          bus.stall     = 1'b1;
          bus.ex_bubble = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
